// File: rtl/solver_result_collector.sv
`default_nettype none
// ============================================================================
// Module  : solver_result_collector
// Purpose : Round-robin collector of solver lane results into frame-buffer writes.
// Revision: 1.0
// ============================================================================
module solver_result_collector #(
    parameter int NUM_SOLVERS = 1,
    parameter int ITER_WIDTH  = 16,
    parameter int COORD_WIDTH = 10,
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int ADDR_WIDTH  = 19
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              frame_start,
    input  logic [NUM_SOLVERS-1:0]            in_valid,
    output logic [NUM_SOLVERS-1:0]            in_ready,
    input  logic [NUM_SOLVERS*COORD_WIDTH-1:0] in_x,
    input  logic [NUM_SOLVERS*COORD_WIDTH-1:0] in_y,
    input  logic [NUM_SOLVERS*ITER_WIDTH-1:0]  in_iter,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [ITER_WIDTH-1:0]             mem_data,
    input  logic                              mem_ready,
    output logic [ADDR_WIDTH-1:0]             pixel_count,
    output logic                              frame_done,
    output logic                              err
);

    localparam int RR_WIDTH = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_COUNT = ADDR_WIDTH'(WIDTH * HEIGHT - 1);

    logic [RR_WIDTH-1:0]    rr;
    logic [RR_WIDTH-1:0]    grant;
    logic [RR_WIDTH-1:0]    rr_next;
    logic                   grant_valid;
    logic                   can_accept;
    logic                   handshake;
    logic                   complete;
    logic                   in_range;
    logic [COORD_WIDTH-1:0] sel_x;
    logic [COORD_WIDTH-1:0] sel_y;
    logic [ITER_WIDTH-1:0]  sel_iter;
    logic [ADDR_WIDTH-1:0]  lin_addr;

    // Scan from the highest offset down so the lane nearest rr wins last.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = NUM_SOLVERS - 1; k >= 0; k--) begin
            idx = int'(rr) + k;
            if (idx >= NUM_SOLVERS) begin
                idx = idx - NUM_SOLVERS;
            end
            if (in_valid[RR_WIDTH'(idx)]) begin
                grant       = RR_WIDTH'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    assign can_accept = !mem_we || mem_ready;
    assign handshake  = grant_valid && can_accept;
    assign complete   = mem_we && mem_ready;

    always_comb begin
        in_ready = '0;
        if (handshake) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign sel_x    = in_x[int'(grant)*COORD_WIDTH +: COORD_WIDTH];
    assign sel_y    = in_y[int'(grant)*COORD_WIDTH +: COORD_WIDTH];
    assign sel_iter = in_iter[int'(grant)*ITER_WIDTH +: ITER_WIDTH];
    assign in_range = (32'(sel_x) < 32'(WIDTH)) && (32'(sel_y) < 32'(HEIGHT));
    assign lin_addr = ADDR_WIDTH'(32'(sel_y) * 32'(WIDTH) + 32'(sel_x));
    assign rr_next  = (int'(grant) == NUM_SOLVERS - 1) ? '0 : grant + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr       <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else if (handshake) begin
            rr <= rr_next;
            if (in_range) begin
                mem_we   <= 1'b1;
                mem_addr <= lin_addr;
                mem_data <= sel_iter;
            end else begin
                mem_we <= 1'b0;
            end
        end else if (complete) begin
            mem_we <= 1'b0;
        end
    end

    // frame_start takes priority over a coincident completion or error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pixel_count <= '0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else if (frame_start) begin
            pixel_count <= '0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (complete && !frame_done) begin
                pixel_count <= pixel_count + 1'b1;
                if (pixel_count == LAST_COUNT) begin
                    frame_done <= 1'b1;
                end
            end
            if (handshake && !in_range) begin
                err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
